// File: rtl/fifo_param.sv
// Parametrised single-clock register FIFO with any depth >= 2, registered or
// first-word-fall-through read, occupancy/threshold flags, flush and sticky error flags.
module fifo_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 5,
  parameter int W_CNT    = $clog2(DEPTH + 1),
  parameter int W_POS    = $clog2(DEPTH),
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic             CLK,
  input  logic             RST_X,
  input  logic             CLR,
  input  logic             ENQ,
  input  logic             DEQ,
  input  logic [WIDTH-1:0] DIN,
  output logic [WIDTH-1:0] DOUT,
  output logic             DOUT_VALID,
  output logic             EMPTY,
  output logic             FULL,
  output logic             ALMOST_EMPTY,
  output logic             ALMOST_FULL,
  output logic [W_CNT-1:0] CNT,
  output logic             OVF,
  output logic             UDF
);

  if ((AF_LEVEL > DEPTH) || (AE_LEVEL >= DEPTH) || (DEPTH < 2)) begin : g_param_err
    $error("fifo_param: illegal parameters DEPTH=%0d AF_LEVEL=%0d AE_LEVEL=%0d",
           DEPTH, AF_LEVEL, AE_LEVEL);
  end

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [W_POS-1:0] head_r;
  logic [W_POS-1:0] tail_r;
  logic [W_CNT-1:0] cnt_r;
  logic             ovf_r;
  logic             udf_r;
  logic             empty_s;
  logic             full_s;
  logic             enq_ok_s;
  logic             deq_ok_s;

  // Pointers wrap explicitly so non-power-of-2 depths work.
  function automatic logic [W_POS-1:0] ptr_inc(input logic [W_POS-1:0] ptr);
    if (ptr == W_POS'(DEPTH - 1)) begin
      ptr_inc = {W_POS{1'b0}};
    end else begin
      ptr_inc = ptr + W_POS'(1);
    end
  endfunction

  assign empty_s  = (cnt_r == {W_CNT{1'b0}});
  assign full_s   = (cnt_r == W_CNT'(DEPTH));
  // Flush swallows any request issued in the same cycle.
  assign enq_ok_s = ENQ && !full_s && !CLR;
  assign deq_ok_s = DEQ && !empty_s && !CLR;

  assign EMPTY        = empty_s;
  assign FULL         = full_s;
  assign ALMOST_EMPTY = (cnt_r <= W_CNT'(AE_LEVEL));
  assign ALMOST_FULL  = (cnt_r >= W_CNT'(AF_LEVEL));
  assign CNT          = cnt_r;
  assign OVF          = ovf_r;
  assign UDF          = udf_r;

  // Storage array: deliberately not reset.
  always_ff @(posedge CLK) begin
    if (enq_ok_s) begin
      mem_r[tail_r] <= DIN;
    end
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      head_r <= {W_POS{1'b0}};
      tail_r <= {W_POS{1'b0}};
      cnt_r  <= {W_CNT{1'b0}};
      ovf_r  <= 1'b0;
      udf_r  <= 1'b0;
    end else if (CLR) begin
      head_r <= {W_POS{1'b0}};
      tail_r <= {W_POS{1'b0}};
      cnt_r  <= {W_CNT{1'b0}};
      ovf_r  <= 1'b0;
      udf_r  <= 1'b0;
    end else begin
      if (enq_ok_s) begin
        tail_r <= ptr_inc(tail_r);
      end
      if (deq_ok_s) begin
        head_r <= ptr_inc(head_r);
      end
      if (enq_ok_s && !deq_ok_s) begin
        cnt_r <= cnt_r + W_CNT'(1);
      end else if (!enq_ok_s && deq_ok_s) begin
        cnt_r <= cnt_r - W_CNT'(1);
      end
      if (ENQ && full_s) begin
        ovf_r <= 1'b1;
      end
      if (DEQ && empty_s) begin
        udf_r <= 1'b1;
      end
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is shown directly; forced to zero while empty so reset gives DOUT=0.
    assign DOUT       = empty_s ? {WIDTH{1'b0}} : mem_r[head_r];
    assign DOUT_VALID = !empty_s;
  end else begin : g_reg_read
    logic [WIDTH-1:0] dout_r;
    logic             dout_valid_r;

    // Registered read port: one-cycle latency, DOUT holds between reads.
    always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
        dout_r       <= {WIDTH{1'b0}};
        dout_valid_r <= 1'b0;
      end else if (CLR) begin
        dout_valid_r <= 1'b0;
      end else if (deq_ok_s) begin
        dout_r       <= mem_r[head_r];
        dout_valid_r <= 1'b1;
      end else begin
        dout_valid_r <= 1'b0;
      end
    end

    assign DOUT       = dout_r;
    assign DOUT_VALID = dout_valid_r;
  end

endmodule

// File: tb/tb_fifo_param.sv
// Drives a registered-read and a FWFT instance of fifo_param with identical traffic
// and compares both against a queue-based reference model.
module tb_fifo_param;

  localparam int WIDTH = 16;
  localparam int DEPTH = 5;
  localparam int AF    = 4;
  localparam int AE    = 1;
  localparam int WC    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_x;
  logic             clr;
  logic             enq;
  logic             deq;
  logic [WIDTH-1:0] din;

  logic [WIDTH-1:0] dout0, dout1;
  logic             vld0, vld1, empty0, empty1, full0, full1;
  logic             ae0, ae1, af0, af1, ovf0, ovf1, udf0, udf1;
  logic [WC-1:0]    cnt0, cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [WIDTH-1:0] q[$];
  logic             m_ovf;
  logic             m_udf;
  logic [WIDTH-1:0] m_dout0;
  logic             m_vld0;

  always #5 clk = ~clk;

  fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_reg (
    .CLK(clk), .RST_X(rst_x), .CLR(clr), .ENQ(enq), .DEQ(deq), .DIN(din),
    .DOUT(dout0), .DOUT_VALID(vld0), .EMPTY(empty0), .FULL(full0),
    .ALMOST_EMPTY(ae0), .ALMOST_FULL(af0), .CNT(cnt0), .OVF(ovf0), .UDF(udf0));

  fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_fwft (
    .CLK(clk), .RST_X(rst_x), .CLR(clr), .ENQ(enq), .DEQ(deq), .DIN(din),
    .DOUT(dout1), .DOUT_VALID(vld1), .EMPTY(empty1), .FULL(full1),
    .ALMOST_EMPTY(ae1), .ALMOST_FULL(af1), .CNT(cnt1), .OVF(ovf1), .UDF(udf1));

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_dout0 = '0;
    m_vld0  = 1'b0;
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check_eq("cnt0",   32'(cnt0),   32'(n));
    check_eq("cnt1",   32'(cnt1),   32'(n));
    check_eq("empty0", 32'(empty0), 32'(n == 0));
    check_eq("empty1", 32'(empty1), 32'(n == 0));
    check_eq("full0",  32'(full0),  32'(n == DEPTH));
    check_eq("full1",  32'(full1),  32'(n == DEPTH));
    check_eq("ae0",    32'(ae0),    32'(n <= AE));
    check_eq("af0",    32'(af0),    32'(n >= AF));
    check_eq("ae1",    32'(ae1),    32'(n <= AE));
    check_eq("af1",    32'(af1),    32'(n >= AF));
    check_eq("ovf0",   32'(ovf0),   32'(m_ovf));
    check_eq("ovf1",   32'(ovf1),   32'(m_ovf));
    check_eq("udf0",   32'(udf0),   32'(m_udf));
    check_eq("udf1",   32'(udf1),   32'(m_udf));
    check_eq("vld0",   32'(vld0),   32'(m_vld0));
    check_eq("vld1",   32'(vld1),   32'(n != 0));
    if (m_vld0) check_eq("dout0", 32'(dout0), 32'(m_dout0));
    if (n != 0) check_eq("dout1", 32'(dout1), 32'(q[0]));
  endtask

  // One clock cycle: apply inputs, advance the model, check after the edge.
  task automatic cycle(input logic e, input logic d, input logic c, input logic [WIDTH-1:0] di);
    bit was_full;
    bit was_empty;
    enq = e; deq = d; clr = c; din = di;
    if (c) begin
      q.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_vld0 = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (e && was_full)  m_ovf = 1'b1;
      if (d && was_empty) m_udf = 1'b1;
      if (d && !was_empty) begin
        m_dout0 = q.pop_front();
        m_vld0  = 1'b1;
      end else begin
        m_vld0 = 1'b0;
      end
      if (e && !was_full) q.push_back(di);
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Reset asserted between edges; outputs must respond with no clock edge.
  task automatic async_reset();
    enq = 1'b0; deq = 1'b0; clr = 1'b0;
    #2 rst_x = 1'b0;
    #1;
    model_reset();
    check_all();
    check_eq("rst_dout0", 32'(dout0), 32'd0);
    check_eq("rst_dout1", 32'(dout1), 32'd0);
    @(negedge clk);
    rst_x = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    bit e, d, c;
    rst_x = 1'b0; clr = 1'b0; enq = 1'b0; deq = 1'b0; din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    check_eq("init_dout0", 32'(dout0), 32'd0);
    check_eq("init_dout1", 32'(dout1), 32'd0);
    @(negedge clk);
    rst_x = 1'b1;

    // fill with overflow, then drain in order
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, WIDTH'(10 + i));
    check_eq("fill_cnt", 32'(cnt0), 32'd5);
    check_eq("fill_ovf", 32'(ovf0), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 1'b0, '0);
      check_eq("drain_dout", 32'(dout0), 32'(10 + i));
    end
    cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b1, '0);

    // FWFT single word latency
    cycle(1'b1, 1'b0, 1'b0, WIDTH'(16'h00A5));
    check_eq("fwft_dout", 32'(dout1), 32'h0000_00A5);
    check_eq("fwft_vld", 32'(vld1), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, '0);
    check_eq("fwft_vld_after", 32'(vld1), 32'd0);

    // steady-state ENQ+DEQ at CNT=2 with pointer wrap
    cycle(1'b1, 1'b0, 1'b0, WIDTH'(1));
    cycle(1'b1, 1'b0, 1'b0, WIDTH'(2));
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, WIDTH'(100 + i));
    check_eq("ss_cnt", 32'(cnt0), 32'd2);

    // ENQ+DEQ when full, then when empty
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, WIDTH'(200 + i));
    cycle(1'b1, 1'b1, 1'b0, WIDTH'(300));
    check_eq("full_both_cnt", 32'(cnt0), 32'd4);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, WIDTH'(301));
    check_eq("empty_both_cnt", 32'(cnt0), 32'd1);
    check_eq("empty_both_udf", 32'(udf0), 32'd1);

    // CLR at CNT=3 with ENQ and OVF set
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, WIDTH'(400 + i));
    cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    check_eq("pre_clr_cnt", 32'(cnt0), 32'd3);
    cycle(1'b1, 1'b0, 1'b1, WIDTH'(77));
    check_eq("clr_cnt", 32'(cnt0), 32'd0);
    check_eq("clr_ovf", 32'(ovf0), 32'd0);

    // random traffic with biased phases, occasional flush and async reset
    for (int i = 0; i < 3000; i++) begin
      e = ($urandom_range(0, 99) < ((i % 400) < 200 ? 70 : 35));
      d = ($urandom_range(0, 99) < ((i % 400) < 200 ? 35 : 70));
      c = ($urandom_range(0, 63) == 0);
      cycle(e, d, c, WIDTH'($urandom));
      if ((i % 700) == 350) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
